// File: rtl/level_controller.sv
// Game-flow controller for whack-a-mole: IDLE/PLAY/OVER sequencing, round timer,
// saturating score and level-driven mole speed. All outputs are registered.
module level_controller #(
    parameter logic [27:0] BASE_SPEED     = 28'd50_000_000,
    parameter logic [27:0] SPEED_STEP     = 28'd5_000_000,
    parameter logic [27:0] MIN_SPEED      = 28'd10_000_000,
    parameter int          HITS_PER_LEVEL = 5,
    parameter int          MAX_LEVEL      = 7,
    parameter int          TICKS_PER_SEC  = 50_000_000,
    parameter int          GAME_SECONDS   = 60
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        hit,
    output logic        game,
    output logic [27:0] speed,
    output logic [2:0]  level,
    output logic [7:0]  score,
    output logic [7:0]  time_left,
    output logic        game_over
);
    localparam int          HCW       = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;
    localparam logic [HCW-1:0] HC_LAST = HCW'(HITS_PER_LEVEL - 1);
    localparam logic [27:0] TICK_LAST = 28'(TICKS_PER_SEC - 1);
    localparam logic [7:0]  SECS      = 8'(GAME_SECONDS);
    localparam logic [2:0]  LVL_MAX   = 3'(MAX_LEVEL);
    localparam logic [28:0] STEP_FLOOR = {1'b0, MIN_SPEED} + {1'b0, SPEED_STEP};

    typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, OVER = 2'b10} state_t;

    state_t         state, state_n;
    logic           start_q;
    logic [27:0]    tick, tick_n;
    logic [HCW-1:0] hcnt, hcnt_n;
    logic           game_n, game_over_n;
    logic [27:0]    speed_n;
    logic [2:0]     level_n;
    logic [7:0]     score_n, time_left_n;
    logic           start_rise;

    assign start_rise = start & ~start_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            start_q   <= 1'b0;
            tick      <= '0;
            hcnt      <= '0;
            game      <= 1'b0;
            game_over <= 1'b0;
            speed     <= BASE_SPEED;
            level     <= '0;
            score     <= '0;
            time_left <= '0;
        end else begin
            state     <= state_n;
            start_q   <= start;
            tick      <= tick_n;
            hcnt      <= hcnt_n;
            game      <= game_n;
            game_over <= game_over_n;
            speed     <= speed_n;
            level     <= level_n;
            score     <= score_n;
            time_left <= time_left_n;
        end
    end

    always_comb begin
        state_n     = state;
        tick_n      = tick;
        hcnt_n      = hcnt;
        game_n      = 1'b0;
        game_over_n = 1'b0;
        speed_n     = speed;
        level_n     = level;
        score_n     = score;
        time_left_n = time_left;

        case (state)
            IDLE, OVER: begin
                if (state == OVER) begin
                    game_over_n = 1'b1;
                    time_left_n = '0;
                end
                if (start_rise) begin
                    state_n     = PLAY;
                    game_n      = 1'b1;
                    game_over_n = 1'b0;
                    score_n     = '0;
                    level_n     = '0;
                    speed_n     = BASE_SPEED;
                    time_left_n = SECS;
                    tick_n      = '0;
                    hcnt_n      = '0;
                end
            end
            PLAY: begin
                game_n = 1'b1;
                if (tick == TICK_LAST) begin
                    tick_n = '0;
                    if (time_left <= 8'd1) begin
                        time_left_n = '0;
                        state_n     = OVER;
                        game_n      = 1'b0;
                        game_over_n = 1'b1;
                    end else begin
                        time_left_n = time_left - 8'd1;
                    end
                end else begin
                    tick_n = tick + 28'd1;
                end
                // A hit on the final timer edge still counts, level-up included.
                if (hit) begin
                    if (score != 8'hFF)
                        score_n = score + 8'd1;
                    if (hcnt == HC_LAST) begin
                        hcnt_n = '0;
                        if (level < LVL_MAX) begin
                            level_n = level + 3'd1;
                            speed_n = ({1'b0, speed} >= STEP_FLOOR) ? speed - SPEED_STEP : MIN_SPEED;
                        end
                    end else begin
                        hcnt_n = hcnt + HCW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_level_controller.sv
// Self-checking bench for level_controller: per-cycle compare against a round-level
// behavioural model, literal checkpoints, random stimulus and a score-saturation run.
module tb_level_controller;
    localparam int TPS = 4, SECS = 3, HPL = 2, BASE = 100, STEP = 30, MINS = 50, MAXL = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n, start, hit;
    logic        game, game_over;
    logic [27:0] speed;
    logic [2:0]  level;
    logic [7:0]  score, time_left;

    logic        b_reset_n, b_start, b_hit;
    logic        b_game, b_game_over;
    logic [27:0] b_speed;
    logic [2:0]  b_level;
    logic [7:0]  b_score, b_time_left;

    level_controller #(
        .BASE_SPEED(28'd100), .SPEED_STEP(28'd30), .MIN_SPEED(28'd50),
        .HITS_PER_LEVEL(HPL), .MAX_LEVEL(MAXL), .TICKS_PER_SEC(TPS), .GAME_SECONDS(SECS)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .hit(hit),
        .game(game), .speed(speed), .level(level), .score(score),
        .time_left(time_left), .game_over(game_over)
    );

    level_controller #(
        .BASE_SPEED(28'd100), .SPEED_STEP(28'd30), .MIN_SPEED(28'd50),
        .HITS_PER_LEVEL(HPL), .MAX_LEVEL(MAXL), .TICKS_PER_SEC(1000), .GAME_SECONDS(SECS)
    ) dut_b (
        .clock(clock), .reset_n(b_reset_n), .start(b_start), .hit(b_hit),
        .game(b_game), .speed(b_speed), .level(b_level), .score(b_score),
        .time_left(b_time_left), .game_over(b_game_over)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Round-level model: phase, cycles elapsed in round, raw hits in round.
    int m_phase = 0;   // 0 idle, 1 play, 2 over
    int m_el    = 0;
    int m_hits  = 0;
    bit m_sq    = 1'b0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_phase <= 0; m_el <= 0; m_hits <= 0; m_sq <= 1'b0;
        end else begin
            m_sq <= start;
            if (m_phase != 1) begin
                if (start && !m_sq) begin
                    m_phase <= 1; m_el <= 0; m_hits <= 0;
                end
            end else begin
                if (hit) m_hits <= m_hits + 1;
                if (m_el + 1 == SECS * TPS) m_phase <= 2;
                m_el <= m_el + 1;
            end
        end
    end

    function automatic int exp_level();
        return (m_hits / HPL > MAXL) ? MAXL : m_hits / HPL;
    endfunction

    function automatic int exp_speed();
        int s;
        s = BASE - exp_level() * STEP;
        return (s < MINS) ? MINS : s;
    endfunction

    always @(negedge clock) begin
        if (chk_en) begin
            chk("game", int'(game), int'(m_phase == 1));
            chk("game_over", int'(game_over), int'(m_phase == 2));
            chk("score", int'(score), (m_hits > 255) ? 255 : m_hits);
            chk("level", int'(level), exp_level());
            chk("speed", int'(speed), exp_speed());
            chk("time_left", int'(time_left), (m_phase == 1) ? SECS - m_el / TPS : 0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; hit = 1'b0;
        b_reset_n = 1'b0; b_start = 1'b0; b_hit = 1'b0;
        cyc(2);
        chk_en = 1'b1;
        reset_n = 1'b1; b_reset_n = 1'b1;

        // Idle with start low
        cyc(10);
        chk("idle_game", int'(game), 0);
        chk("idle_speed", int'(speed), 100);
        chk("idle_time", int'(time_left), 0);

        // Round timing
        start = 1'b1;
        cyc(1);
        chk("start_game", int'(game), 1);
        chk("start_time", int'(time_left), 3);
        cyc(4);
        chk("time_k4", int'(time_left), 2);
        cyc(4);
        chk("time_k8", int'(time_left), 1);
        chk("game_k11", int'(game), 1);
        cyc(4);
        chk("over_game", int'(game), 0);
        chk("over_flag", int'(game_over), 1);
        chk("over_time", int'(time_left), 0);

        // Restart, then hits and level progression
        start = 1'b0; cyc(1);
        start = 1'b1; cyc(1);
        for (int i = 1; i <= 8; i++) begin
            hit = 1'b1;
            cyc(1);
            if (i == 2) begin chk("lvl1", int'(level), 1); chk("spd1", int'(speed), 70); end
            if (i == 4) begin chk("lvl2", int'(level), 2); chk("spd2", int'(speed), 50); end
            if (i == 6) begin chk("lvl3", int'(level), 3); chk("spd3", int'(speed), 50); chk("score6", int'(score), 6); end
        end
        hit = 1'b0;
        chk("score8", int'(score), 8);
        chk("lvl_cap", int'(level), 3);
        chk("spd_cap", int'(speed), 50);

        // Hit on the final timer edge
        cyc(3);
        hit = 1'b1;
        cyc(1);
        chk("last_hit_score", int'(score), 9);
        chk("last_hit_over", int'(game_over), 1);
        cyc(3);
        hit = 1'b0;
        chk("over_hits_ignored", int'(score), 9);
        cyc(4);
        chk("held_start_no_restart", int'(game), 0);
        start = 1'b0; cyc(1);
        start = 1'b1; cyc(1);
        chk("restart_game", int'(game), 1);
        chk("restart_score", int'(score), 0);
        chk("restart_speed", int'(speed), 100);
        chk("restart_time", int'(time_left), 3);

        // Asynchronous reset between edges mid-round
        cyc(3);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_game", int'(game), 0);
        chk("rst_over", int'(game_over), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_time", int'(time_left), 0);
        chk("rst_speed", int'(speed), 100);
        start = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        cyc(5);
        chk("post_rst_idle", int'(game), 0);
        start = 1'b1;
        cyc(1);
        chk("post_rst_start", int'(game), 1);

        // Random traffic, model-checked every cycle
        for (int i = 0; i < 600; i++) begin
            hit = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) start = ~start;
            if ($urandom_range(0, 199) == 0) begin
                #1 reset_n = 1'b0;
                #2 reset_n = 1'b1;
            end
            cyc(1);
        end
        hit = 1'b0;

        // Score saturation on the slow-timer instance
        b_start = 1'b1;
        cyc(1);
        chk("b_start", int'(b_game), 1);
        for (int i = 1; i <= 300; i++) begin
            b_hit = 1'b1;
            cyc(1);
            chk("b_score", int'(b_score), (i > 255) ? 255 : i);
        end
        b_hit = 1'b0;
        chk("b_still_playing", int'(b_game), 1);
        chk("b_level", int'(b_level), 3);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
